// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefNregs = 8;

endpackage

// File: rtl/regfile_if.sv
// Write/read/clear bus of the register file; master drives requests, slave is the regfile.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREGS = DefNregs
) ();

  localparam int unsigned AW = $clog2(NREGS);

  logic             write;
  logic [AW-1:0]    writenum;
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    readnum_a;
  logic [AW-1:0]    readnum_b;
  logic [WIDTH-1:0] data_out_a;
  logic [WIDTH-1:0] data_out_b;
  logic             clear_req;
  logic             busy;
  logic             wr_drop;

  modport master (
    output write, writenum, data_in, readnum_a, readnum_b, clear_req,
    input  data_out_a, data_out_b, busy, wr_drop
  );

  modport slave (
    input  write, writenum, data_in, readnum_a, readnum_b, clear_req,
    output data_out_a, data_out_b, busy, wr_drop
  );

endinterface

// File: rtl/onehot_decoder.sv
// Binary index to one-hot vector, all-zero when not enabled.
module onehot_decoder #(
  parameter int unsigned N = 8
) (
  input  logic [$clog2(N)-1:0] idx_i,
  input  logic                 en_i,
  output logic [N-1:0]         oh_o
);

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/regfile_mp.sv
// NREGS x WIDTH register file: one write port, two combinational read ports,
// optional bypass / hard-wired R0, and a one-register-per-cycle bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NREGS   = DefNregs,
  parameter bit          BYPASS  = 1'b0,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  clr_state_e       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             wr_acc;
  logic             clr_en;
  logic [NREGS-1:0] wr_oh;
  logic [NREGS-1:0] clr_oh;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Next-state logic; a clear request in IDLE wins over a same-cycle write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wr_acc      = bus.write && (state_q == IDLE) && !bus.clear_req;
    clr_en      = (state_q == CLEAR);
    wr_drop_d   = bus.write && !wr_acc;
    bus.busy    = (state_q == CLEAR);
    bus.wr_drop = wr_drop_q;
  end

  onehot_decoder #(.N(NREGS)) u_wr_dec (
    .idx_i (bus.writenum),
    .en_i  (wr_acc),
    .oh_o  (wr_oh)
  );

  onehot_decoder #(.N(NREGS)) u_clr_dec (
    .idx_i (cnt_q),
    .en_i  (clr_en),
    .oh_o  (clr_oh)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (clr_oh[i]) begin
        regs_d[i] = '0;
      end else if (wr_oh[i] && !(ZERO_R0 && i == 0)) begin
        regs_d[i] = bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Zero-R0 overrides bypass; bypass only applies to an accepted write.
  always_comb begin
    bus.data_out_a = regs_q[bus.readnum_a];
    if (BYPASS && wr_acc && bus.writenum == bus.readnum_a) bus.data_out_a = bus.data_in;
    if (ZERO_R0 && bus.readnum_a == '0) bus.data_out_a = '0;

    bus.data_out_b = regs_q[bus.readnum_b];
    if (BYPASS && wr_acc && bus.writenum == bus.readnum_b) bus.data_out_b = bus.data_in;
    if (ZERO_R0 && bus.readnum_b == '0) bus.data_out_b = '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven in lockstep, checked against an array model.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  logic        cur_wr;
  logic [2:0]  cur_wn;
  logic [15:0] cur_din;
  logic [2:0]  cur_ra;
  logic [2:0]  cur_rb;
  logic        cur_cr;

  int checks;
  int failures;

  // Reference state: plain register array, clear progress as cycles remaining.
  logic [15:0] mem [8];
  int          clr_left;
  logic        drop_m;

  regfile_if #(.WIDTH(16), .NREGS(8)) ifa ();
  regfile_if #(.WIDTH(16), .NREGS(8)) ifb ();

  assign ifa.write     = cur_wr;
  assign ifa.writenum  = cur_wn;
  assign ifa.data_in   = cur_din;
  assign ifa.readnum_a = cur_ra;
  assign ifa.readnum_b = cur_rb;
  assign ifa.clear_req = cur_cr;
  assign ifb.write     = cur_wr;
  assign ifb.writenum  = cur_wn;
  assign ifb.data_in   = cur_din;
  assign ifb.readnum_a = cur_ra;
  assign ifb.readnum_b = cur_rb;
  assign ifb.clear_req = cur_cr;

  regfile_mp #(.WIDTH(16), .NREGS(8), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  regfile_mp #(.WIDTH(16), .NREGS(8), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit acc_now();
    return cur_wr && (clr_left == 0) && !cur_cr;
  endfunction

  function automatic logic [15:0] exp_read(input bit zr, input bit byp, input logic [2:0] idx);
    if (zr && idx == 3'd0) return 16'h0000;
    if (byp && acc_now() && cur_wn == idx) return cur_din;
    return mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    clr_left = 0;
    drop_m   = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    acc = acc_now();
    if (clr_left > 0) begin
      mem[8 - clr_left] = 16'h0000;
      clr_left--;
    end else if (cur_cr) begin
      clr_left = 8;
    end else if (acc) begin
      mem[cur_wn] = cur_din;
    end
    drop_m = cur_wr && !acc;
  endtask

  task automatic check_model();
    chk("a_rd_a", ifa.data_out_a, exp_read(1'b0, 1'b0, cur_ra));
    chk("a_rd_b", ifa.data_out_b, exp_read(1'b0, 1'b0, cur_rb));
    chk("b_rd_a", ifb.data_out_a, exp_read(1'b1, 1'b1, cur_ra));
    chk("b_rd_b", ifb.data_out_b, exp_read(1'b1, 1'b1, cur_rb));
    chk("a_busy", 16'(ifa.busy), 16'(clr_left > 0));
    chk("b_busy", 16'(ifb.busy), 16'(clr_left > 0));
    chk("a_drop", 16'(ifa.wr_drop), 16'(drop_m));
    chk("b_drop", 16'(ifb.wr_drop), 16'(drop_m));
  endtask

  task automatic apply(input logic wr, input int wn, input logic [15:0] din,
                       input int ra, input int rb, input logic cr);
    @(negedge clk);
    cur_wr  = wr;
    cur_wn  = wn[2:0];
    cur_din = din;
    cur_ra  = ra[2:0];
    cur_rb  = rb[2:0];
    cur_cr  = cr;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    cur_wr   = 1'b0;
    cur_wn   = 3'd0;
    cur_din  = 16'h0000;
    cur_ra   = 3'd0;
    cur_rb   = 3'd0;
    cur_cr   = 1'b0;
    model_reset();

    // Reset contents on both ports
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cur_ra = 3'(i);
      cur_rb = 3'(7 - i);
      #1;
      chk("rst_a", ifa.data_out_a, 16'h0000);
      chk("rst_b", ifa.data_out_b, 16'h0000);
    end
    chk("rst_busy", 16'(ifa.busy), 16'h0000);
    chk("rst_drop", 16'(ifa.wr_drop), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then dual read
    apply(1'b1, 3, 16'hBEEF, 0, 0, 1'b0); tick();
    apply(1'b1, 5, 16'h1234, 0, 0, 1'b0); tick();
    apply(1'b0, 0, 16'h0000, 3, 5, 1'b0);
    chk("rd3_a", ifa.data_out_a, 16'hBEEF);
    chk("rd5_b", ifa.data_out_b, 16'h1234);
    tick();
    apply(1'b0, 0, 16'h0000, 3, 3, 1'b0);
    chk("same_a", ifa.data_out_a, 16'hBEEF);
    chk("same_b", ifa.data_out_b, 16'hBEEF);
    tick();

    // Bypass vs. no bypass
    apply(1'b1, 2, 16'hA5A5, 2, 2, 1'b0);
    chk("byp_on", ifb.data_out_a, 16'hA5A5);
    chk("byp_off", ifa.data_out_a, 16'h0000);
    tick();
    apply(1'b0, 0, 16'h0000, 2, 2, 1'b0);
    chk("byp_off_next", ifa.data_out_a, 16'hA5A5);
    tick();

    // Hard-wired R0
    apply(1'b1, 0, 16'hFFFF, 0, 0, 1'b0);
    chk("r0_before", ifb.data_out_a, 16'h0000);
    tick();
    apply(1'b0, 0, 16'h0000, 0, 0, 1'b0);
    chk("r0_after", ifb.data_out_a, 16'h0000);
    chk("r0_plain", ifa.data_out_a, 16'hFFFF);
    tick();

    // Fill, then clear colliding with a write
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, k, 16'(16'h1000 + k), k, 7 - k, 1'b0); tick();
    end
    apply(1'b1, 1, 16'hDEAD, 1, 1, 1'b1); tick();
    for (int c = 0; c <= 8; c++) begin
      apply((c < 8) ? 1'(c % 2) : 1'b0, c % 8, 16'hCAFE, (c == 0) ? 0 : c - 1, 7,
            (c == 2) ? 1'b1 : 1'b0);
      chk("clr_busy", 16'(ifa.busy), (c < 8) ? 16'h0001 : 16'h0000);
      if (c == 0) chk("clr_drop", 16'(ifa.wr_drop), 16'h0001);
      if (c >= 1) chk("clr_prog", ifa.data_out_a, 16'h0000);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 0, 16'h0000, k, k, 1'b0);
      chk("clr_all", ifa.data_out_a, 16'h0000);
      tick();
    end

    // Reset mid-clear
    apply(1'b0, 0, 16'h0000, 0, 0, 1'b1); tick();
    repeat (3) begin
      apply(1'b0, 0, 16'h0000, 0, 0, 1'b0); tick();
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk("mid_busy", 16'(ifa.busy), 16'h0000);
    for (int i = 0; i < 8; i++) begin
      cur_ra = 3'(i);
      cur_rb = 3'(i);
      #1;
      check_model();
      chk("mid_rd", ifa.data_out_a, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 7, 16'h0042, 7, 7, 1'b0); tick();
    apply(1'b0, 0, 16'h0000, 7, 7, 1'b0);
    chk("post_rst", ifa.data_out_a, 16'h0042);
    tick();

    // Randomized traffic
    repeat (400) begin
      apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
